// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, mux selects,
// ALUOp codes, FSM state encodings and the flat control word.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11
    } state_e;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_source;
        logic       instr_done;
    } ctrl_t;

    function automatic logic op_legal(input logic [5:0] op, input logic addi_en);
        case (op)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J: op_legal = 1'b1;
            OP_ADDI:                              op_legal = addi_en;
            default:                              op_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_decode.sv
// Moore output decode: maps the current state (plus mem_ready for the
// stall-gated writes) to the datapath control word.
module multicycle_control_decode
    import mips_pkg::*;
(
    input  state_e state_i,
    input  logic   mem_ready_i,
    output ctrl_t  ctrl_o
);

    always_comb begin
        ctrl_o = '0;
        case (state_i)
            S_FETCH: begin
                // PC and IR load only in the completing cycle so a stalled fetch updates them once
                ctrl_o.mem_read  = 1'b1;
                ctrl_o.ir_write  = mem_ready_i;
                ctrl_o.pc_write  = mem_ready_i;
                ctrl_o.alu_src_b = SRCB_FOUR;
            end
            S_DECODE:    ctrl_o.alu_src_b = SRCB_IMMSH;
            S_MEM_ADDR: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_MEM_READ: begin
                ctrl_o.mem_read = 1'b1;
                ctrl_o.iord     = 1'b1;
            end
            S_MEM_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.mem_to_reg = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_MEM_WRITE: begin
                ctrl_o.mem_write  = 1'b1;
                ctrl_o.iord       = 1'b1;
                ctrl_o.instr_done = mem_ready_i;
            end
            S_EXECUTE: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_op    = ALUOP_FUNCT;
            end
            S_R_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.reg_dst    = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            S_BRANCH: begin
                ctrl_o.alu_src_a     = 1'b1;
                ctrl_o.alu_op        = ALUOP_SUB;
                ctrl_o.pc_write_cond = 1'b1;
                ctrl_o.pc_source     = PCSRC_ALUOUT;
                ctrl_o.instr_done    = 1'b1;
            end
            S_JUMP: begin
                ctrl_o.pc_write   = 1'b1;
                ctrl_o.pc_source  = PCSRC_JUMP;
                ctrl_o.instr_done = 1'b1;
            end
            S_ADDI_EXEC: begin
                ctrl_o.alu_src_a = 1'b1;
                ctrl_o.alu_src_b = SRCB_IMM;
            end
            S_ADDI_WB: begin
                ctrl_o.reg_write  = 1'b1;
                ctrl_o.instr_done = 1'b1;
            end
            default: ctrl_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: holds the state register,
// dispatches on opcode, and drives the datapath enables via the decode block.
module multicycle_control
    import mips_pkg::*;
#(
    parameter int ADDI_EN = 1,
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic               mem_ready,
    output logic               PCWrite,
    output logic               PCWriteCond,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               MemtoReg,
    output logic               RegDst,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic               instr_done,
    output logic               illegal_op,
    output logic [STATE_W-1:0] state_dbg
);

    localparam logic ADDI_OK = (ADDI_EN != 0);

    state_e state_q, state_d;
    ctrl_t  ctrl;
    ctrl_t  ctrl_gated;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:      state_d = S_EXECUTE;
                    OP_LW, OP_SW:  state_d = S_MEM_ADDR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = ADDI_OK ? S_ADDI_EXEC : S_FETCH;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW)      state_d = S_MEM_READ;
                else if (opcode == OP_SW) state_d = S_MEM_WRITE;
                else                      state_d = S_FETCH;
            end
            S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
            S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
            S_EXECUTE:   state_d = S_R_WB;
            S_ADDI_EXEC: state_d = S_ADDI_WB;
            S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
            default:     state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    multicycle_control_decode u_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl)
    );

    // Reset forces every enable low so an abandoned instruction cannot write back
    assign ctrl_gated  = reset ? '0 : ctrl;

    assign PCWrite     = ctrl_gated.pc_write;
    assign PCWriteCond = ctrl_gated.pc_write_cond;
    assign IorD        = ctrl_gated.iord;
    assign MemRead     = ctrl_gated.mem_read;
    assign MemWrite    = ctrl_gated.mem_write;
    assign IRWrite     = ctrl_gated.ir_write;
    assign MemtoReg    = ctrl_gated.mem_to_reg;
    assign RegDst      = ctrl_gated.reg_dst;
    assign RegWrite    = ctrl_gated.reg_write;
    assign ALUSrcA     = ctrl_gated.alu_src_a;
    assign ALUSrcB     = ctrl_gated.alu_src_b;
    assign ALUOp       = ctrl_gated.alu_op;
    assign PCSource    = ctrl_gated.pc_source;
    assign instr_done  = ctrl_gated.instr_done;

    assign illegal_op  = !reset && (state_q == S_DECODE) && !op_legal(opcode, ADDI_OK);
    assign state_dbg   = reset ? '0 : STATE_W'(state_q);

endmodule

// File: tb/tb_multicycle_control.sv
// Directed scoreboard bench for multicycle_control: expected per-cycle control
// words are queued per instruction and popped against the DUT each cycle.
module tb_multicycle_control;

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mrd, mwr, irw, m2r, rdst, rw, asa;
        logic [1:0] asb, aop, pcs;
        logic       done, ill;
    } obs_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;

    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, RegDst, RegWrite, ALUSrcA, instr_done, illegal_op;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state_dbg;

    logic       n_PCWrite, n_PCWriteCond, n_IorD, n_MemRead, n_MemWrite, n_IRWrite;
    logic       n_MemtoReg, n_RegDst, n_RegWrite, n_ALUSrcA, n_instr_done, n_illegal_op;
    logic [1:0] n_ALUSrcB, n_ALUOp, n_PCSource;
    logic [3:0] n_state_dbg;

    int n_asrt = 0;
    int n_fail = 0;
    obs_t exp_q[$];

    always #5 clk = ~clk;

    multicycle_control #(.ADDI_EN(1), .STATE_W(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
        .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .instr_done(instr_done), .illegal_op(illegal_op), .state_dbg(state_dbg)
    );

    multicycle_control #(.ADDI_EN(0), .STATE_W(4)) dut_noaddi (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(n_PCWrite), .PCWriteCond(n_PCWriteCond), .IorD(n_IorD),
        .MemRead(n_MemRead), .MemWrite(n_MemWrite), .IRWrite(n_IRWrite),
        .MemtoReg(n_MemtoReg), .RegDst(n_RegDst), .RegWrite(n_RegWrite),
        .ALUSrcA(n_ALUSrcA), .ALUSrcB(n_ALUSrcB), .ALUOp(n_ALUOp), .PCSource(n_PCSource),
        .instr_done(n_instr_done), .illegal_op(n_illegal_op), .state_dbg(n_state_dbg)
    );

    // Reference control word for a state, straight from the output table
    function automatic obs_t model(input logic [3:0] st, input logic mr, input logic ill);
        obs_t o;
        o = '0;
        o.st = st;
        case (st)
            4'd0:  begin o.mrd = 1; o.irw = mr; o.pcw = mr; o.asb = 2'b01; end
            4'd1:  begin o.asb = 2'b11; o.ill = ill; end
            4'd2:  begin o.asa = 1; o.asb = 2'b10; end
            4'd3:  begin o.mrd = 1; o.iord = 1; end
            4'd4:  begin o.rw = 1; o.m2r = 1; o.done = 1; end
            4'd5:  begin o.mwr = 1; o.iord = 1; o.done = mr; end
            4'd6:  begin o.asa = 1; o.aop = 2'b10; end
            4'd7:  begin o.rw = 1; o.rdst = 1; o.done = 1; end
            4'd8:  begin o.asa = 1; o.aop = 2'b01; o.pcwc = 1; o.pcs = 2'b01; o.done = 1; end
            4'd9:  begin o.pcw = 1; o.pcs = 2'b10; o.done = 1; end
            4'd10: begin o.asa = 1; o.asb = 2'b10; end
            4'd11: begin o.rw = 1; o.done = 1; end
            default: o = '0;
        endcase
        return o;
    endfunction

    task automatic push(input logic [3:0] st, input logic mr, input logic ill = 1'b0);
        exp_q.push_back(model(st, mr, ill));
    endtask

    task automatic push_rst();
        exp_q.push_back('0);
    endtask

    // One clock: drive inputs, sample mid-cycle against the queue head, advance
    task automatic cyc(input string tag, input logic rst, input logic mr, input logic [5:0] op);
        obs_t got, want;
        reset = rst; mem_ready = mr; opcode = op;
        #1;
        got = {state_dbg, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite,
               MemtoReg, RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
               instr_done, illegal_op};
        n_asrt++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $error("FAIL %s: observed %h, scoreboard empty", tag, got);
        end else begin
            want = exp_q.pop_front();
            assert (got === want) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", tag, got, want);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
        n_asrt++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    initial begin
        reset = 1'b1; mem_ready = 1'b1; opcode = 6'b000000;
        @(posedge clk);
        #1;

        // Reset held three cycles, then FETCH fetches immediately
        repeat (3) push_rst();
        repeat (3) cyc("reset", 1, 1, 6'b000000);

        // R-type: 0,1,6,7
        push(0, 1); push(1, 1); push(6, 1); push(7, 1);
        repeat (4) cyc("rtype", 0, 1, 6'b000000);

        // lw with two stall cycles in FETCH and in MEM_READ: 9 cycles
        push(0, 0); push(0, 0); push(0, 1); push(1, 1); push(2, 1);
        push(3, 0); push(3, 0); push(3, 1); push(4, 1);
        cyc("lw_f0", 0, 0, 6'b100011);
        cyc("lw_f1", 0, 0, 6'b100011);
        cyc("lw_f2", 0, 1, 6'b100011);
        cyc("lw_dec", 0, 1, 6'b100011);
        cyc("lw_addr", 0, 1, 6'b100011);
        cyc("lw_rd0", 0, 0, 6'b100011);
        cyc("lw_rd1", 0, 0, 6'b100011);
        cyc("lw_rd2", 0, 1, 6'b100011);
        cyc("lw_wb", 0, 1, 6'b100011);

        // sw with one write stall
        push(0, 1); push(1, 1); push(2, 1); push(5, 0); push(5, 1);
        cyc("sw_f", 0, 1, 6'b101011);
        cyc("sw_dec", 0, 1, 6'b101011);
        cyc("sw_addr", 0, 1, 6'b101011);
        cyc("sw_wr0", 0, 0, 6'b101011);
        cyc("sw_wr1", 0, 1, 6'b101011);

        // beq and j: 3 cycles each
        push(0, 1); push(1, 1); push(8, 1);
        repeat (3) cyc("beq", 0, 1, 6'b000100);
        push(0, 1); push(1, 1); push(9, 1);
        repeat (3) cyc("jump", 0, 1, 6'b000010);

        // Illegal opcode: pulse in DECODE, straight back to FETCH
        push(0, 1); push(1, 1, 1'b1); push(0, 1);
        cyc("ill_f", 0, 1, 6'b111111);
        cyc("ill_dec", 0, 1, 6'b111111);
        cyc("ill_back", 0, 1, 6'b000000);
        // The follow-up FETCH went to DECODE; finish that as an R-type
        push(1, 1); push(6, 1); push(7, 1);
        repeat (3) cyc("rtype2", 0, 1, 6'b000000);

        // addi: supported in dut, illegal in dut_noaddi
        push(0, 1); push(1, 1); push(10, 1); push(11, 1);
        cyc("addi_f", 0, 1, 6'b001000);
        reset = 0; mem_ready = 1; opcode = 6'b001000;
        #1;
        chk("noaddi_ill", {7'd0, n_illegal_op}, 8'd1);
        chk("noaddi_dec", {4'd0, n_state_dbg}, 8'd1);
        cyc("addi_dec", 0, 1, 6'b001000);
        chk("noaddi_back", {4'd0, n_state_dbg}, 8'd0);
        chk("noaddi_nowr", {6'd0, n_RegWrite, n_MemWrite}, 8'd0);
        cyc("addi_exec", 0, 1, 6'b001000);
        cyc("addi_wb", 0, 1, 6'b001000);
        // Resynchronise both instances
        push_rst();
        cyc("resync", 1, 1, 6'b000000);

        // Reset in MEM_READ abandons the lw without write-back
        push(0, 1); push(1, 1); push(2, 1); push(3, 0); push_rst(); push(0, 1); push(1, 1);
        cyc("rlw_f", 0, 1, 6'b100011);
        cyc("rlw_dec", 0, 1, 6'b100011);
        cyc("rlw_addr", 0, 1, 6'b100011);
        cyc("rlw_rd", 0, 0, 6'b100011);
        cyc("rlw_rst", 1, 0, 6'b100011);
        cyc("rlw_fetch", 0, 1, 6'b000000);
        cyc("rlw_dec2", 0, 1, 6'b000000);

        chk("sb_drained", 8'(exp_q.size()), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
